uart_tx_8n1: RTL and testbench
==============================

Name: uart_tx_8n1

Overview:
- Serial transmitter for the board UART, directly downstream of the command parser.
- Consumes the parser's byte and level-style start request (`tx_start`/`tx_data`) and returns a ready flag.
- Drives the FPGA TXD pin with 8N1 frames: 1 start bit, 8 data bits LSB first, 1 stop bit, no parity.
- Bit timing comes from a clock-cycle divider, so no separate baud-clock domain exists.

Parameters:
- CLKS_PER_BIT, 434, system clock cycles per serial bit (50 MHz / 115200). Legal range 2..65535.
- CNT_W, $clog2(CLKS_PER_BIT), width of the bit-period counter. Derived; never overridden.

Ports:
- clk  input  1  system clock; all logic on its rising edge.
- rstn  input  1  asynchronous active-low reset.
- tx_start_i  input  1  level request to send tx_data_i; sampled only while idle.
- tx_data_i  input  8  byte to send; captured at the acceptance edge.
- tx_ready_o  output  1  1 = idle and able to accept; 0 = frame in progress.
- txd_o  output  1  serial line; idles high.

Behaviour:
- One clock; reset is asynchronous and active-low (clk, rstn).
- Reset values: state=IDLE, txd_o=1, tx_ready_o=1, shift register=0, bit-period counter=0, bit index=0.
- Reset asserted mid-frame aborts the frame immediately: txd_o=1 and tx_ready_o=1 without waiting for a clock.
- All outputs come straight from registers; no combinational path from inputs to outputs.

States:
- IDLE:
  - tx_ready_o=1, txd_o=1.
  - At an edge where tx_start_i=1, that edge is the acceptance edge T0. At T0:
    - shift register <= tx_data_i;
    - txd_o <= 0;
    - tx_ready_o <= 0;
    - counter <= 0;
    - state <= START.
- START:
  - txd_o holds 0.
  - Counter increments each cycle.
  - On the edge where counter == CLKS_PER_BIT-1:
    - counter <= 0;
    - bit index <= 0;
    - txd_o <= shift[0];
    - state <= DATA.
- DATA:
  - On each edge where counter == CLKS_PER_BIT-1:
    - counter <= 0;
    - shift right by 1;
    - bit index +1.
  - On the bit where index == 7 completes: txd_o <= 1 and state <= STOP.
  - Otherwise txd_o <= next LSB.
- STOP:
  - txd_o holds 1 for CLKS_PER_BIT cycles.
  - At terminal count: state <= IDLE and tx_ready_o <= 1.

Timing:
- Each bit is exactly CLKS_PER_BIT cycles on txd_o.
- txd_o falls at T0+1 (registered).
- tx_ready_o falls at T0+1 and rises exactly 10*CLKS_PER_BIT cycles after it fell.

Handshake:
- tx_start_i is level-sensitive and ignored outside IDLE.
- tx_data_i changes after T0 do not affect the frame in flight.
- If tx_start_i is still 1 on the first IDLE cycle after a frame, a new frame is accepted at that edge. tx_ready_o is then high for exactly one cycle, which is the back-to-back case.
- The parser's own protocol (raise start on ready, drop start on !ready) therefore yields one frame per request.
- tx_start_i=0 in IDLE: outputs stay at 1 indefinitely.

Arithmetic:
- The counter compares against CLKS_PER_BIT-1 at full CNT_W width and never exceeds it; no wrap is ever observable.
- The bit index is 3 bits.

Test Plan:
(All with CLKS_PER_BIT=4 unless stated.)
1. Reset, then hold tx_start_i=0 for 100 cycles -> txd_o=1 and tx_ready_o=1 throughout.
2. Pulse tx_start_i for 1 cycle with tx_data_i=8'hA5 -> txd_o sequence, each held 4 cycles: 0,1,0,1,0,0,1,0,1,1. tx_ready_o low for exactly 40 cycles, then high.
3. Parser-style handshake: raise start with 8'h0A when ready, drop it when ready=0. Change tx_data_i to 8'hFF during the frame -> frame still carries 8'h0A. Exactly one frame sent.
4. Hold tx_start_i=1 continuously with 8'h55 -> back-to-back frames. tx_ready_o high for 1 cycle between frames. Line decodes 0x55 each time, with no extra idle bits.
5. Start a frame with 8'h00, assert rstn=0 during DATA bit 3 -> txd_o=1 and tx_ready_o=1 asynchronously. After release, idle until the next tx_start_i.
6. CLKS_PER_BIT=434, send 8'h41 ("A") -> the bench UART receiver model at 115200 baud, 50 MHz, decodes 0x41 with correct framing (start=0, stop=1).

Source files
------------

// File: rtl/uart_tx_8n1.sv
// uart_tx_8n1: 8N1 serial transmitter for the board UART.
// Takes a level-style start request and a byte from the command parser.
// Sends 1 start bit, 8 data bits LSB first, and 1 stop bit on txd_o.
// Bit timing is a plain clock-cycle divider (CLKS_PER_BIT cycles per bit).
//
// Handshake: tx_start_i is a level request and is only looked at while
// tx_ready_o=1 (IDLE).
// The edge on which tx_start_i=1 is seen in IDLE is the acceptance edge.
// tx_data_i is captured on that edge, and tx_ready_o drops right after it.
// tx_ready_o rises again 10*CLKS_PER_BIT cycles later.
// If tx_start_i is still high on that first idle cycle, the next frame
// starts immediately (back-to-back).
//
// dbg_state_o exposes the FSM state for checkers and debug.
module uart_tx_8n1 #(
    parameter int CLKS_PER_BIT = 434,
    localparam int CNT_W = $clog2(CLKS_PER_BIT)
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       tx_start_i,
    input  logic [7:0] tx_data_i,
    output logic       tx_ready_o,
    output logic       txd_o,
    output logic [1:0] dbg_state_o
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    // Terminal value of the bit-period counter; the counter never exceeds it.
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [7:0]       r_shift;
    logic [7:0]       w_shift_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [2:0]       r_idx;
    logic [2:0]       w_idx_nxt;
    logic             r_txd;
    logic             w_txd_nxt;
    logic             r_ready;
    logic             w_ready_nxt;
    logic             w_last;

    assign w_last      = (r_cnt == LAST_CNT);
    assign tx_ready_o  = r_ready;
    assign txd_o       = r_txd;
    assign dbg_state_o = r_state;

    // State and output registers; reset aborts any frame and idles the line.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= S_IDLE;
            r_shift <= '0;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_txd   <= 1'b1;
            r_ready <= 1'b1;
        end else begin
            r_state <= w_state_nxt;
            r_shift <= w_shift_nxt;
            r_cnt   <= w_cnt_nxt;
            r_idx   <= w_idx_nxt;
            r_txd   <= w_txd_nxt;
            r_ready <= w_ready_nxt;
        end
    end

    // Next-state and next-output logic; every register holds unless changed.
    always_comb begin
        w_state_nxt = r_state;
        w_shift_nxt = r_shift;
        w_cnt_nxt   = r_cnt;
        w_idx_nxt   = r_idx;
        w_txd_nxt   = r_txd;
        w_ready_nxt = r_ready;
        case (r_state)
            S_IDLE: begin
                w_txd_nxt   = 1'b1;
                w_ready_nxt = 1'b1;
                if (tx_start_i) begin
                    w_shift_nxt = tx_data_i;
                    w_txd_nxt   = 1'b0;
                    w_ready_nxt = 1'b0;
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_START;
                end
            end
            S_START: begin
                if (w_last) begin
                    w_cnt_nxt   = '0;
                    w_idx_nxt   = 3'd0;
                    w_txd_nxt   = r_shift[0];
                    w_state_nxt = S_DATA;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            S_DATA: begin
                if (w_last) begin
                    w_cnt_nxt   = '0;
                    w_shift_nxt = r_shift >> 1;
                    w_idx_nxt   = r_idx + 3'd1;
                    if (r_idx == 3'd7) begin
                        w_txd_nxt   = 1'b1;
                        w_state_nxt = S_STOP;
                    end else begin
                        // Bit 1 becomes the LSB after this edge's shift.
                        w_txd_nxt = r_shift[1];
                    end
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            S_STOP: begin
                w_txd_nxt = 1'b1;
                if (w_last) begin
                    w_cnt_nxt   = '0;
                    w_ready_nxt = 1'b1;
                    w_state_nxt = S_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_tx_8n1.sv
// Testbench for uart_tx_8n1.
// A fast instance (4 clocks per bit) runs the table, random, back-to-back
// and reset sequences.
// A 434-clock instance at 50 MHz is decoded by a time-based 115200-baud
// receiver model.
// The expected line level for sample k after acceptance is bit k/P of the
// frame {stop=1, data, start=0}, sent LSB first.
`timescale 1ns/1ps
module tb_uart_tx_8n1;

    localparam int P      = 4;
    localparam int P2     = 434;
    localparam int CLK_NS = 20;
    localparam int BIT_NS = 8681;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rstn;
    always #(CLK_NS/2) clk = ~clk;

    logic       tx_start, tx_start2;
    logic [7:0] tx_data, tx_data2;
    logic       tx_ready, tx_ready2;
    logic       txd, txd2;
    logic [1:0] dbg_state, dbg_state2;

    uart_tx_8n1 #(.CLKS_PER_BIT(P)) dut (
        .clk(clk), .rstn(rstn), .tx_start_i(tx_start), .tx_data_i(tx_data),
        .tx_ready_o(tx_ready), .txd_o(txd), .dbg_state_o(dbg_state)
    );

    uart_tx_8n1 #(.CLKS_PER_BIT(P2)) dut_baud (
        .clk(clk), .rstn(rstn), .tx_start_i(tx_start2), .tx_data_i(tx_data2),
        .tx_ready_o(tx_ready2), .txd_o(txd2), .dbg_state_o(dbg_state2)
    );

    // ---------------- scoreboard ----------------
    int n_cmp = 0;
    int n_bad = 0;
    logic [7:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Reference model: the frame as sent, start bit at index 0.
    function automatic logic [9:0] frame_of(input logic [7:0] d);
        return {1'b1, d, 1'b0};
    endfunction

    typedef struct {
        logic [7:0] data;
        logic       hold;
        logic       change;
        logic [7:0] new_data;
        logic [9:0] exp_frame;
    } vec_t;

    vec_t vecs[5];

    // ---------------- driver tasks ----------------
    // Called at a negedge with the DUT idle. It raises start and checks
    // every cycle of the frame against exp. On return it is at the negedge
    // of the first cycle after the frame.
    task automatic run_frame(input string tag, input logic [7:0] d, input logic [9:0] exp,
                             input bit hold, input bit change, input logic [7:0] new_d);
        check({tag, "_pre_ready"}, 32'(tx_ready), 32'd1);
        check({tag, "_pre_txd"}, 32'(txd), 32'd1);
        tx_start = 1'b1;
        tx_data  = d;
        @(negedge clk);
        if (!hold) tx_start = 1'b0;
        if (change) tx_data = new_d;
        for (int k = 0; k < 10*P; k++) begin
            check($sformatf("%s_txd_k%0d", tag, k), 32'(txd), 32'(exp[k/P]));
            check($sformatf("%s_ready_k%0d", tag, k), 32'(tx_ready), 32'd0);
            @(negedge clk);
        end
    endtask

    task automatic idle_check(input string tag, input int n);
        for (int i = 0; i < n; i++) begin
            check($sformatf("%s_ready_%0d", tag, i), 32'(tx_ready), 32'd1);
            check($sformatf("%s_txd_%0d", tag, i), 32'(txd), 32'd1);
            @(negedge clk);
        end
    endtask

    initial begin
        #(5_000_000);
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    // ---------------- main sequence ----------------
    initial begin
        logic [7:0] rd;
        logic [7:0] rx_byte;
        logic       rx_bit;
        int         gap;
        bit         seen;

        rstn = 1'b0; tx_start = 1'b0; tx_data = 8'h00;
        tx_start2 = 1'b0; tx_data2 = 8'h00;

        vecs[0] = '{data:8'hA5, hold:1'b0, change:1'b0, new_data:8'h00, exp_frame:10'h34A};
        vecs[1] = '{data:8'h0A, hold:1'b0, change:1'b1, new_data:8'hFF, exp_frame:10'h214};
        vecs[2] = '{data:8'h55, hold:1'b1, change:1'b0, new_data:8'h00, exp_frame:10'h2AA};
        vecs[3] = '{data:8'h55, hold:1'b1, change:1'b0, new_data:8'h00, exp_frame:10'h2AA};
        vecs[4] = '{data:8'h55, hold:1'b0, change:1'b0, new_data:8'h00, exp_frame:10'h2AA};

        // Reset values while rstn is held low.
        repeat (3) @(negedge clk);
        check("rst_ready", 32'(tx_ready), 32'd1);
        check("rst_txd", 32'(txd), 32'd1);
        check("rst_ready2", 32'(tx_ready2), 32'd1);
        check("rst_txd2", 32'(txd2), 32'd1);
        rstn = 1'b1;
        @(negedge clk);

        // Idle with no request.
        idle_check("idle100", 100);

        // Table: A5 pulse, 0A with data changed mid-frame, 55 back-to-back x3.
        for (int v = 0; v < 5; v++) begin
            run_frame($sformatf("vec%0d", v), vecs[v].data, vecs[v].exp_frame,
                      vecs[v].hold, vecs[v].change, vecs[v].new_data);
        end
        idle_check("post_b2b", 12);

        // Randomized frames with random idle gaps and data churn.
        for (int r = 0; r < 8; r++) begin
            rd  = 8'($urandom);
            gap = $urandom_range(0, 3);
            idle_check($sformatf("rgap%0d", r), gap);
            run_frame($sformatf("rnd%0d", r), rd, frame_of(rd), 1'b0, 1'b1, 8'($urandom));
        end
        idle_check("post_rnd", 5);

        // Reset during data bit 3 of a 0x00 frame aborts without a clock.
        check("abort_pre_ready", 32'(tx_ready), 32'd1);
        tx_start = 1'b1;
        tx_data  = 8'h00;
        @(negedge clk);
        tx_start = 1'b0;
        repeat (4*P + 1) @(negedge clk);
        check("abort_mid_txd", 32'(txd), 32'd0);
        check("abort_mid_ready", 32'(tx_ready), 32'd0);
        #3 rstn = 1'b0;
        #1;
        check("abort_async_txd", 32'(txd), 32'd1);
        check("abort_async_ready", 32'(tx_ready), 32'd1);
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        idle_check("post_abort", 20);
        run_frame("recover", 8'h3C, frame_of(8'h3C), 1'b0, 1'b0, 8'h00);
        idle_check("post_recover", 4);

        // 434 clocks/bit instance, decoded by a 115200-baud receiver model.
        exp_q.push_back(8'h41);
        check("baud_pre_ready", 32'(tx_ready2), 32'd1);
        tx_start2 = 1'b1;
        tx_data2  = 8'h41;
        @(negedge clk);
        tx_start2 = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (txd2 == 1'b0) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("rx_start_seen", 32'(seen), 32'd1);
        if (seen) begin
            #(BIT_NS/2 - CLK_NS/2);
            rx_bit = txd2;
            check("rx_start_bit", 32'(rx_bit), 32'd0);
            rx_byte = 8'h00;
            for (int b = 0; b < 8; b++) begin
                #(BIT_NS);
                rx_byte[b] = txd2;
            end
            #(BIT_NS);
            rx_bit = txd2;
            check("rx_stop_bit", 32'(rx_bit), 32'd1);
            check("rx_byte", 32'(rx_byte), 32'(exp_q.pop_front()));
            seen = 1'b0;
            for (int i = 0; i < 2*P2; i++) begin
                @(negedge clk);
                if (tx_ready2 == 1'b1) begin
                    seen = 1'b1;
                    break;
                end
            end
            check("rx_ready_back", 32'(seen), 32'd1);
        end
        check("rx_queue_empty", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
